// File: rtl/flag_select_arb.sv
// rtl/flag_select_arb.sv - N-channel flag arbiter with minimum grant hold and registered data select
module flag_select_arb #(
    parameter  int N    = 2,
    parameter  int W    = 1,
    parameter  int MODE = 1,
    parameter  int HOLD = 1,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N*W-1:0]    din,
    input  logic [N-1:0]      flag,
    output logic [W-1:0]      q,
    output logic              q_valid,
    output logic [SELW-1:0]   sel,
    output logic              sel_change
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    if (N < 2 || N > 16 || W < 1 || W > 32 || HOLD < 1 || HOLD > 16 ||
        (MODE != 0 && MODE != 1)) begin : g_param_err
        $error("flag_select_arb: parameter out of range");
    end

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [SELW-1:0] r_ptr, w_ptr_nxt;
    logic [SELW-1:0] r_sel, w_sel_nxt;
    logic [W-1:0]    r_q, w_q_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_chg, w_chg_nxt;
    logic            w_any;
    logic [SELW-1:0] w_win;

    function automatic logic [W-1:0] chan_data(input logic [SELW-1:0] idx);
        chan_data = din[int'(idx)*W +: W];
    endfunction

    function automatic logic [SELW-1:0] fp_pick(input logic [N-1:0] f);
        fp_pick = '0;
        for (int k = N - 1; k >= 0; k--)
            if (f[k]) fp_pick = SELW'(k);
    endfunction

    // Descending scan so the requester closest to start (cyclically) is written last.
    function automatic logic [SELW-1:0] rr_pick(input logic [N-1:0] f,
                                               input logic [SELW-1:0] start);
        int idx;
        rr_pick = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N;
            if (f[idx]) rr_pick = SELW'(idx);
        end
    endfunction

    function automatic logic [SELW-1:0] ptr_after(input logic [SELW-1:0] idx);
        ptr_after = (int'(idx) == N - 1) ? '0 : idx + SELW'(1);
    endfunction

    assign w_any = |flag;
    assign w_win = (MODE == 0) ? fp_pick(flag) : rr_pick(flag, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_q_nxt     = r_q;
        w_valid_nxt = r_valid;
        w_chg_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win;
                    w_q_nxt     = chan_data(w_win);
                    w_valid_nxt = 1'b1;
                    w_chg_nxt   = 1'b1;
                    w_cnt_nxt   = CW'(HOLD - 1);
                    w_ptr_nxt   = ptr_after(w_win);
                end
            end
            S_GRANT: begin
                w_q_nxt = chan_data(r_sel);
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_any) begin
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                    w_q_nxt     = r_q;
                end else if (w_win != r_sel) begin
                    // While granted the pointer sits at sel+1, so the RR pick is the next requester after sel.
                    w_sel_nxt = w_win;
                    w_q_nxt   = chan_data(w_win);
                    w_chg_nxt = 1'b1;
                    w_cnt_nxt = CW'(HOLD - 1);
                    w_ptr_nxt = ptr_after(w_win);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
            r_chg   <= w_chg_nxt;
        end else begin
            r_chg <= 1'b0;
        end
    end

    assign q          = r_q;
    assign q_valid    = r_valid;
    assign sel        = r_sel;
    assign sel_change = r_chg;

endmodule

// File: tb/tb_flag_select_arb.sv
// tb/tb_flag_select_arb.sv - directed bench for flag_select_arb in several configurations
module tb_flag_select_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: N=2 W=1 MODE=0 HOLD=1
    logic        rst_a, en_a;
    logic [1:0]  din_a, flag_a;
    logic        q_a, qv_a, sel_a, chg_a;
    // B: N=4 W=8 MODE=1 HOLD=1
    logic        rst_b, en_b;
    logic [31:0] din_b;
    logic [3:0]  flag_b;
    logic [7:0]  q_b;
    logic        qv_b, chg_b;
    logic [1:0]  sel_b;
    // C: N=4 W=8 MODE=1 HOLD=4
    logic        rst_c, en_c;
    logic [31:0] din_c;
    logic [3:0]  flag_c;
    logic [7:0]  q_c;
    logic        qv_c, chg_c;
    logic [1:0]  sel_c;

    flag_select_arb #(.N(2), .W(1), .MODE(0), .HOLD(1)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .din(din_a), .flag(flag_a),
        .q(q_a), .q_valid(qv_a), .sel(sel_a), .sel_change(chg_a));
    flag_select_arb #(.N(4), .W(8), .MODE(1), .HOLD(1)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .din(din_b), .flag(flag_b),
        .q(q_b), .q_valid(qv_b), .sel(sel_b), .sel_change(chg_b));
    flag_select_arb #(.N(4), .W(8), .MODE(1), .HOLD(4)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .din(din_c), .flag(flag_c),
        .q(q_c), .q_valid(qv_c), .sel(sel_c), .sel_change(chg_c));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_sel_b [5];
    logic [7:0] exp_q_b   [5];

    initial begin
        rst_a = 1'b1; en_a = 1'b1; din_a = '0; flag_a = '0;
        rst_b = 1'b1; en_b = 1'b1; din_b = '0; flag_b = '0;
        rst_c = 1'b1; en_c = 1'b1; din_c = '0; flag_c = '0;
        @(negedge clk);
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        chk("rst_q",     {31'd0, q_a},  32'd0);
        chk("rst_valid", {31'd0, qv_a}, 32'd0);
        chk("rst_sel",   {31'd0, sel_a}, 32'd0);
        chk("rst_chg",   {31'd0, chg_a}, 32'd0);
        chk("rst_c_q",   {24'd0, q_c},  32'd0);

        // Test 1: two-channel fixed priority
        flag_a = 2'b11; din_a = 2'b01; tick();
        chk("t1_sel0",  {31'd0, sel_a}, 32'd0);
        chk("t1_q0",    {31'd0, q_a},   32'd1);
        chk("t1_v0",    {31'd0, qv_a},  32'd1);
        chk("t1_chg0",  {31'd0, chg_a}, 32'd1);
        din_a = 2'b10; tick();
        chk("t1_sel1",  {31'd0, sel_a}, 32'd0);
        chk("t1_q1",    {31'd0, q_a},   32'd0);
        chk("t1_chg1",  {31'd0, chg_a}, 32'd0);
        din_a = 2'b01; tick();
        chk("t1_q2",    {31'd0, q_a},   32'd1);
        flag_a = 2'b10; din_a = 2'b11; tick();
        chk("t1_sw_sel", {31'd0, sel_a}, 32'd1);
        chk("t1_sw_chg", {31'd0, chg_a}, 32'd1);
        chk("t1_sw_q",   {31'd0, q_a},   32'd1);
        flag_a = 2'b00; din_a = 2'b00; tick();
        chk("t1_idle_v", {31'd0, qv_a}, 32'd0);
        chk("t1_idle_q", {31'd0, q_a},  32'd1);

        // Test 2: round-robin fairness
        exp_sel_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q_b   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        flag_b = 4'hF; din_b = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2_sel%0d", i), {30'd0, sel_b}, {30'd0, exp_sel_b[i]});
            chk($sformatf("t2_q%0d", i),   {24'd0, q_b},   {24'd0, exp_q_b[i]});
            chk($sformatf("t2_chg%0d", i), {31'd0, chg_b}, 32'd1);
        end

        // Test 3: hold enforcement, flag[0] dropped in hold cycle 2
        flag_c = 4'b0011; din_c = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t3_hold_sel%0d", i), {30'd0, sel_c}, 32'd0);
            chk($sformatf("t3_hold_chg%0d", i), {31'd0, chg_c}, (i == 1) ? 32'd1 : 32'd0);
            if (i == 2) flag_c = 4'b0010;
        end
        tick();
        chk("t3_sw_sel", {30'd0, sel_c}, 32'd1);
        chk("t3_sw_chg", {31'd0, chg_c}, 32'd1);
        chk("t3_sw_q",   {24'd0, q_c},   32'hB1);
        tick();
        chk("t3_h2_sel", {30'd0, sel_c}, 32'd1);

        // Test 4: enable freeze with counter at 2
        en_c = 1'b0; flag_c = 4'b0101; din_c = {8'hD3, 8'hC2, 8'h77, 8'hA0};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_fz_q%0d", i),   {24'd0, q_c},   32'hB1);
            chk($sformatf("t4_fz_sel%0d", i), {30'd0, sel_c}, 32'd1);
            chk($sformatf("t4_fz_v%0d", i),   {31'd0, qv_c},  32'd1);
            chk($sformatf("t4_fz_chg%0d", i), {31'd0, chg_c}, 32'd0);
        end
        en_c = 1'b1;
        tick();
        chk("t4_r1_sel", {30'd0, sel_c}, 32'd1);
        chk("t4_r1_q",   {24'd0, q_c},   32'h77);
        tick();
        chk("t4_r2_sel", {30'd0, sel_c}, 32'd1);
        tick();
        chk("t4_r3_sel", {30'd0, sel_c}, 32'd2);
        chk("t4_r3_chg", {31'd0, chg_c}, 32'd1);
        chk("t4_r3_q",   {24'd0, q_c},   32'hC2);

        // Test 5: reset during grant to channel 2 while en=0
        rst_c = 1'b1; en_c = 1'b0; tick();
        chk("t5_q",   {24'd0, q_c},   32'd0);
        chk("t5_v",   {31'd0, qv_c},  32'd0);
        chk("t5_sel", {30'd0, sel_c}, 32'd0);
        rst_c = 1'b0; en_c = 1'b1; flag_c = 4'hF; tick();
        chk("t5_g_sel", {30'd0, sel_c}, 32'd0);
        chk("t5_g_chg", {31'd0, chg_c}, 32'd1);
        chk("t5_g_q",   {24'd0, q_c},   32'hA0);

        // Test 6: reach sel=1 with hold expired, then 0010 -> 1000
        flag_c = 4'b0010;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_pre_sel0", {30'd0, sel_c}, 32'd0);
        tick();
        chk("t6_sel1", {30'd0, sel_c}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_keep_sel", {30'd0, sel_c}, 32'd1);
        chk("t6_keep_chg", {31'd0, chg_c}, 32'd0);
        flag_c = 4'b1000; tick();
        chk("t6_sw_sel", {30'd0, sel_c}, 32'd3);
        chk("t6_sw_v",   {31'd0, qv_c},  32'd1);
        chk("t6_sw_chg", {31'd0, chg_c}, 32'd1);
        chk("t6_sw_q",   {24'd0, q_c},   32'hD3);

        // All flags drop: IDLE only after the hold expires
        flag_c = 4'b0000;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_hold_v", {31'd0, qv_c}, 32'd1);
        tick();
        chk("t6_idle_v", {31'd0, qv_c}, 32'd0);
        chk("t6_idle_q", {24'd0, q_c},  32'hD3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
